rtype_sequencer: RTL and testbench
==================================

// Module: rtype_sequencer
// PURPOSE
//  Multi-cycle controller for the RV32 R-type datapath (register bank + ALU).
//  Fetches 32-bit instructions over a req/ack memory port, decodes R-type fields,
//  drives register-bank read/write addresses and ALU control, and advances the PC.
//  Sits between instruction memory and the processor datapath.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on rst and on every accepted start
//  MAX_INSTR  16             retire count at which the run ends (1..2^CNT_W-1)
//  CNT_W      16             width of the retired-instruction counter
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst         in   1      reset, synchronous, active-high
//  start       in   1      pulse; begins a run when in IDLE or DONE
//  imem_req    out  1      fetch request, held until imem_ack
//  imem_addr   out  32     fetch address (= pc)
//  imem_ack    in   1      fetch data valid this cycle; ignored unless imem_req=1
//  imem_rdata  in   32     instruction word, sampled when imem_req & imem_ack
//  rf_raddr1   out  5      rs1 address (instr[19:15])
//  rf_raddr2   out  5      rs2 address (instr[24:20])
//  rf_waddr    out  5      rd address (instr[11:7])
//  rf_we       out  1      register write enable, one cycle per retired instruction
//  alu_cs      out  4      ALU select = {instr[30], instr[14:12]}
//  pc          out  32     current program counter
//  retired     out  CNT_W  instructions retired in this run
//  busy        out  1      high in FETCH/DECODE/EXEC/WB
//  done        out  1      high while in DONE
//  illegal     out  1      sticky; set on any non-R-type or bad funct7, cleared on start
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, retired=0, instr reg=0; imem_req, rf_we, busy,
//   done, illegal=0; alu_cs and all rf addresses=0. rst wins over every other input,
//   including mid-fetch: imem_req drops the cycle after rst is sampled.
//  FSM states: IDLE, FETCH, DECODE, EXEC, WB, DONE.
//  IDLE/DONE: start=1 -> FETCH; pc=RESET_PC, retired=0, illegal=0. Otherwise hold.
//  FETCH: imem_req=1, imem_addr=pc. On imem_ack: latch imem_rdata -> DECODE.
//   Without ack: stay in FETCH, no timeout. start is ignored in every busy state.
//  DECODE: instr==32'h0 -> DONE (halt word; not retired, pc unchanged).
//   Legal: opcode==7'b0110011 AND (funct7==7'h00, OR funct7==7'h20 with
//   funct3 in {000,101}) -> EXEC.
//   Otherwise: illegal<=1, pc<=pc+4, no write, not retired -> FETCH.
//  EXEC: rf_raddr1/2 and alu_cs valid; one cycle for register read and ALU settling
//   -> WB.
//  WB: rf_we=1 for exactly this cycle unless rd==0 (x0 is never written);
//   pc<=pc+4 (mod 2^32, wraps silently); retired<=retired+1.
//   Then -> DONE if retired+1==MAX_INSTR, else -> FETCH.
//  rf_raddr*, rf_waddr and alu_cs are registered from the latched instruction and
//   stay stable from DECODE until the next fetch is accepted.
//  Latency: 4 cycles per legal instruction with zero-wait ack (FETCH, DECODE, EXEC,
//   WB). Each wait cycle on imem_ack adds 1 cycle.
//  retired saturates at MAX_INSTR and never wraps within a run.
// TESTING
//  1. ADD x3,x1,x2 (32'h002081B3), ack same cycle, MAX_INSTR=1
//     -> rf_we pulses in cycle 4 with waddr=3, alu_cs=4'b0000;
//     then done=1, retired=1, pc=4.
//  2. SUB (32'h402081B3) then SRA (32'h4020D1B3)
//     -> alu_cs=4'b1000, then alu_cs=4'b1101; pc=8.
//  3. Word 32'h00000013 (ADDI) or 32'h402091B3 (bad funct7)
//     -> illegal=1, rf_we never asserted, pc+=4, fetch continues.
//  4. imem_ack delayed 3 cycles -> imem_req and imem_addr held constant;
//     instruction latency=7 cycles; then halt word 0 -> done=1, retired unchanged.
//  5. rd=0 (32'h00208033) -> no rf_we pulse, retired increments.
//     rst asserted during FETCH -> next cycle IDLE, imem_req=0, pc=RESET_PC.
//  6. start asserted while busy -> ignored.
//     start in DONE -> retired=0, illegal=0, new fetch issued at RESET_PC.

Source files
------------

// File: rtl/rtype_sequencer.sv
// rtl/rtype_sequencer.sv - multi-cycle fetch/decode/exec/writeback controller for the RV32 R-type datapath
module rtype_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_INSTR = 16,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    output logic [4:0]       rf_waddr,
    output logic             rf_we,
    output logic [3:0]       alu_cs,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] retired,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSTR);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [2:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_retired;
    logic             r_illegal;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic             w_halt;
    logic             w_legal;
    logic [CNT_W-1:0] w_retired_next;
    logic             w_last;

    assign w_opcode       = r_instr[6:0];
    assign w_funct3       = r_instr[14:12];
    assign w_funct7       = r_instr[31:25];
    assign w_halt         = (r_instr == 32'h0000_0000);
    // funct7=0x20 is only meaningful for SUB (000) and SRA (101)
    assign w_legal        = (w_opcode == 7'b0110011) &&
                            ((w_funct7 == 7'h00) ||
                             ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
    assign w_retired_next = r_retired + ONE_CNT;
    assign w_last         = (w_retired_next == MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'h0000_0000;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_pc      <= RESET_PC;
                        r_retired <= '0;
                        r_illegal <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_halt) begin
                        r_state <= S_DONE;
                    end else if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_illegal <= 1'b1;
                        r_pc      <= r_pc + 32'd4;
                        r_state   <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_pc <= r_pc + 32'd4;
                    if (r_retired != MAX_CNT) begin
                        r_retired <= w_retired_next;
                    end
                    r_state <= w_last ? S_DONE : S_FETCH;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Register-bank and ALU controls come straight from the latched word, so they
    // hold from DECODE until the next fetch is accepted.
    assign rf_raddr1 = r_instr[19:15];
    assign rf_raddr2 = r_instr[24:20];
    assign rf_waddr  = r_instr[11:7];
    assign alu_cs    = {r_instr[30], r_instr[14:12]};
    assign rf_we     = (r_state == S_WB) && (r_instr[11:7] != 5'd0);

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign retired   = r_retired;
    assign busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                       (r_state == S_EXEC)  || (r_state == S_WB);
    assign done      = (r_state == S_DONE);
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_rtype_sequencer.sv
// tb/tb_rtype_sequencer.sv - directed-vector bench for rtype_sequencer
module tb_rtype_sequencer;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic [4:0]       rf_raddr1;
    logic [4:0]       rf_raddr2;
    logic [4:0]       rf_waddr;
    logic             rf_we;
    logic [3:0]       alu_cs;
    logic [31:0]      pc;
    logic [CNT_W-1:0] retired;
    logic             busy;
    logic             done;
    logic             illegal;

    rtype_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .MAX_INSTR (3),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .alu_cs     (alu_cs),
        .pc         (pc),
        .retired    (retired),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRA  = 32'h4020D1B3;
    localparam logic [31:0] I_ADDI = 32'h00000013;
    localparam logic [31:0] I_BADF = 32'h402091B3;
    localparam logic [31:0] I_RD0  = 32'h00208033;

    int          vectors;
    int          miscompares;
    int          ack_delay;
    int          wait_cnt;
    int          we_cnt;
    logic [31:0] mem [64];
    logic [4:0]  q_waddr [$];
    logic [3:0]  q_alu [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: acks after ack_delay wait cycles of a held request
    always @(negedge clk) begin
        imem_rdata = mem[imem_addr[7:2]];
        if (imem_req) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && rf_we) begin
            we_cnt = we_cnt + 1;
            q_waddr.push_back(rf_waddr);
            q_alu.push_back(alu_cs);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3,
                        input logic [31:0] w4);
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3; mem[4] = w4;
        we_cnt = 0;
        q_waddr.delete();
        q_alu.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({imem_req, rf_we, busy, done, illegal} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_flags: req/we/busy/done/ill=%b required 00000",
                     {imem_req, rf_we, busy, done, illegal});
        end
        vectors++;
        if (pc !== 32'h0 || retired !== '0) begin
            miscompares++;
            $display("FAIL reset_pc: pc=%h retired=%0d required 0/0", pc, retired);
        end
        vectors++;
        if ({rf_raddr1, rf_raddr2, rf_waddr, alu_cs} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_ctrl: addrs/alu=%h required 0", {rf_raddr1, rf_raddr2, rf_waddr, alu_cs});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        load(I_ADD, 32'h0, 32'h0, 32'h0, 32'h0);
        ack_delay = 0;
        pulse_start();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL add_fetch: req=%b addr=%h busy=%b required 1/0/1", imem_req, imem_addr, busy);
        end
        step();
        step();
        step();
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || alu_cs !== 4'b0000) begin
            miscompares++;
            $display("FAIL add_wb: we=%b waddr=%0d alu=%b required 1/3/0000", rf_we, rf_waddr, alu_cs);
        end
        vectors++;
        if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin
            miscompares++;
            $display("FAIL add_raddr: rs1=%0d rs2=%0d required 1/2", rf_raddr1, rf_raddr2);
        end
        wait_done("add");
        vectors++;
        if (retired !== 16'd1 || pc !== 32'd4 || we_cnt !== 1) begin
            miscompares++;
            $display("FAIL add_end: retired=%0d pc=%h we_cnt=%0d required 1/4/1", retired, pc, we_cnt);
        end
    endtask

    task automatic test_sub_sra();
        load(I_SUB, I_SRA, 32'h0, 32'h0, 32'h0);
        pulse_start();
        wait_done("subsra");
        vectors++;
        if (q_alu.size() !== 2) begin
            miscompares++;
            $display("FAIL subsra_count: writes=%0d required 2", q_alu.size());
        end else begin
            vectors++;
            if (q_alu[0] !== 4'b1000 || q_alu[1] !== 4'b1101) begin
                miscompares++;
                $display("FAIL subsra_alu: alu=%b,%b required 1000,1101", q_alu[0], q_alu[1]);
            end
        end
        vectors++;
        if (pc !== 32'd8 || retired !== 16'd2) begin
            miscompares++;
            $display("FAIL subsra_end: pc=%h retired=%0d required 8/2", pc, retired);
        end
    endtask

    task automatic test_illegal();
        load(I_ADDI, I_BADF, I_ADD, 32'h0, 32'h0);
        pulse_start();
        wait_done("illegal");
        vectors++;
        if (illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_flag: illegal=%b required 1", illegal);
        end
        vectors++;
        if (we_cnt !== 1 || retired !== 16'd1 || pc !== 32'd12) begin
            miscompares++;
            $display("FAIL illegal_end: we_cnt=%0d retired=%0d pc=%h required 1/1/c", we_cnt, retired, pc);
        end
    endtask

    task automatic test_restart_from_done();
        load(I_ADD, 32'h0, 32'h0, 32'h0, 32'h0);
        pulse_start();
        vectors++;
        if (illegal !== 1'b0 || retired !== '0) begin
            miscompares++;
            $display("FAIL restart_clear: illegal=%b retired=%0d required 0/0", illegal, retired);
        end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL restart_fetch: req=%b addr=%h required 1/0", imem_req, imem_addr);
        end
        wait_done("restart");
    endtask

    task automatic test_wait_states();
        int cyc;
        int req_cycles;
        int addr_bad;
        load(I_ADD, 32'h0, 32'h0, 32'h0, 32'h0);
        ack_delay = 3;
        pulse_start();
        cyc = 1;
        req_cycles = 0;
        addr_bad = 0;
        while (!rf_we && cyc < 30) begin
            if (imem_req) begin
                req_cycles++;
                if (imem_addr !== 32'h0) addr_bad++;
            end
            step();
            cyc++;
        end
        vectors++;
        if (cyc !== 7) begin
            miscompares++;
            $display("FAIL wait_latency: rf_we in cycle %0d required 7", cyc);
        end
        vectors++;
        if (req_cycles !== 4 || addr_bad !== 0) begin
            miscompares++;
            $display("FAIL wait_req_hold: req cycles=%0d addr changes=%0d required 4/0", req_cycles, addr_bad);
        end
        wait_done("wait");
        vectors++;
        if (retired !== 16'd1 || pc !== 32'd4) begin
            miscompares++;
            $display("FAIL wait_halt: retired=%0d pc=%h required 1/4", retired, pc);
        end
        ack_delay = 0;
    endtask

    task automatic test_rd0();
        load(I_RD0, 32'h0, 32'h0, 32'h0, 32'h0);
        pulse_start();
        wait_done("rd0");
        vectors++;
        if (we_cnt !== 0 || retired !== 16'd1) begin
            miscompares++;
            $display("FAIL rd0: we_cnt=%0d retired=%0d required 0/1", we_cnt, retired);
        end
    endtask

    task automatic test_max_instr();
        load(I_ADD, I_SUB, I_ADD, I_SRA, I_ADD);
        pulse_start();
        wait_done("max");
        vectors++;
        if (retired !== 16'd3 || pc !== 32'd12 || we_cnt !== 3) begin
            miscompares++;
            $display("FAIL max_end: retired=%0d pc=%h we_cnt=%0d required 3/c/3", retired, pc, we_cnt);
        end
        step();
        step();
        vectors++;
        if (retired !== 16'd3 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL max_hold: retired=%0d req=%b required 3/0", retired, imem_req);
        end
    endtask

    task automatic test_start_busy();
        int n;
        load(I_ADD, I_ADD, 32'h0, 32'h0, 32'h0);
        pulse_start();
        n = 0;
        while (retired !== 16'd1 && n < 30) begin
            step();
            n++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (pc !== 32'd4 || retired !== 16'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_start: pc=%h retired=%0d busy=%b required 4/1/1", pc, retired, busy);
        end
        wait_done("busy");
        vectors++;
        if (retired !== 16'd2 || pc !== 32'd8) begin
            miscompares++;
            $display("FAIL busy_end: retired=%0d pc=%h required 2/8", retired, pc);
        end
    endtask

    task automatic test_rst_in_fetch();
        int n;
        load(I_ADD, I_ADD, 32'h0, 32'h0, 32'h0);
        pulse_start();
        n = 0;
        while (retired !== 16'd1 && n < 30) begin
            step();
            n++;
        end
        ack_delay = 20;
        step();
        vectors++;
        if (imem_req !== 1'b1 || pc !== 32'd4) begin
            miscompares++;
            $display("FAIL rst_prefetch: req=%b pc=%h required 1/4", imem_req, pc);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || busy !== 1'b0 || retired !== '0) begin
            miscompares++;
            $display("FAIL rst_fetch: req=%b pc=%h busy=%b retired=%0d required 0/0/0/0",
                     imem_req, pc, busy, retired);
        end
        ack_delay = 0;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ack_delay   = 0;
        wait_cnt    = 0;
        we_cnt      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_add();
        test_sub_sra();
        test_illegal();
        test_restart_from_done();
        test_wait_states();
        test_rd0();
        test_max_instr();
        test_start_busy();
        test_rst_in_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
